// File: rtl/msrv32_machine_control.sv
// rtl/msrv32_machine_control.sv - machine-mode trap/MRET sequencer for the msrv32 core
module msrv32_machine_control #(
    parameter int RESET_CYCLES = 1
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       misaligned_exception_out,
    output logic       instret_inc_out
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        STATE_RESET       = 2'b00,
        STATE_OPERATING   = 2'b01,
        STATE_TRAP_TAKEN  = 2'b10,
        STATE_TRAP_RETURN = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_rst_cnt;
    logic [3:0]      r_cause;
    logic            r_i_or_e;

    logic            w_sys;
    logic            w_ecall;
    logic            w_ebreak;
    logic            w_mret;
    logic            w_exception;
    logic            w_irq;
    logic            w_ext_irq;
    logic            w_sw_irq;
    logic            w_tmr_irq;
    logic [3:0]      w_exc_cause;
    logic [3:0]      w_irq_cause;
    logic            w_misaligned;

    assign w_sys    = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_sys && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign w_ebreak = w_sys && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign w_mret   = w_sys && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

    assign w_misaligned = misaligned_instr_in | misaligned_load_in | misaligned_store_in;
    assign w_exception  = w_misaligned | illegal_instr_in | w_ebreak | w_ecall;

    assign w_ext_irq = meie_in & meip_in;
    assign w_sw_irq  = msie_in & msip_in;
    assign w_tmr_irq = mtie_in & mtip_in;
    assign w_irq     = mie_in & (w_ext_irq | w_sw_irq | w_tmr_irq);

    always_comb begin
        w_exc_cause = 4'd11;
        if (misaligned_instr_in)      w_exc_cause = 4'd0;
        else if (illegal_instr_in)    w_exc_cause = 4'd2;
        else if (w_ebreak)            w_exc_cause = 4'd3;
        else if (misaligned_load_in)  w_exc_cause = 4'd4;
        else if (misaligned_store_in) w_exc_cause = 4'd6;
    end

    always_comb begin
        w_irq_cause = 4'd7;
        if (w_ext_irq)     w_irq_cause = 4'd11;
        else if (w_sw_irq) w_irq_cause = 4'd3;
    end

    // Cause and interrupt flag are captured only on the OPERATING->TRAP_TAKEN edge
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_state   <= STATE_RESET;
            r_rst_cnt <= '0;
            r_cause   <= 4'd0;
            r_i_or_e  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == STATE_RESET) begin
                r_rst_cnt <= r_rst_cnt + CW'(1);
            end
            if (r_state == STATE_OPERATING) begin
                if (w_exception) begin
                    r_cause  <= w_exc_cause;
                    r_i_or_e <= 1'b0;
                end else if (w_irq) begin
                    r_cause  <= w_irq_cause;
                    r_i_or_e <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STATE_RESET: begin
                if (r_rst_cnt == CW'(RESET_CYCLES - 1)) w_next_state = STATE_OPERATING;
            end
            STATE_OPERATING: begin
                if (w_exception || w_irq) w_next_state = STATE_TRAP_TAKEN;
                else if (w_mret)          w_next_state = STATE_TRAP_RETURN;
            end
            STATE_TRAP_TAKEN:  w_next_state = STATE_OPERATING;
            STATE_TRAP_RETURN: w_next_state = STATE_OPERATING;
            default:           w_next_state = STATE_RESET;
        endcase
    end

    always_comb begin
        pc_src_out               = 2'b00;
        flush_out                = 1'b0;
        trap_taken_out           = 1'b0;
        set_epc_out              = 1'b0;
        set_cause_out            = 1'b0;
        mie_clear_out            = 1'b0;
        mie_set_out              = 1'b0;
        instret_inc_out          = 1'b0;
        misaligned_exception_out = 1'b0;
        case (r_state)
            STATE_RESET: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
            STATE_OPERATING: begin
                pc_src_out               = 2'b11;
                instret_inc_out          = 1'b1;
                misaligned_exception_out = w_misaligned;
            end
            STATE_TRAP_TAKEN: begin
                pc_src_out     = 2'b10;
                flush_out      = 1'b1;
                trap_taken_out = 1'b1;
                set_epc_out    = 1'b1;
                set_cause_out  = 1'b1;
                mie_clear_out  = 1'b1;
            end
            STATE_TRAP_RETURN: begin
                pc_src_out  = 2'b01;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
            default: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out  = r_cause;
    assign i_or_e_out = r_i_or_e;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// tb/tb_msrv32_machine_control.sv - directed bench for msrv32_machine_control
module tb_msrv32_machine_control;

    logic       clk;
    logic       rst;
    logic       illegal_instr, misaligned_instr, misaligned_load, misaligned_store;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
    logic [1:0] pc_src;
    logic       flush, trap_taken, set_epc, set_cause, i_or_e;
    logic [3:0] cause;
    logic       mie_clear, mie_set, mis_exc, instret_inc;

    int n_cmp = 0;
    int n_mis = 0;

    msrv32_machine_control #(.RESET_CYCLES(1)) dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_in     (rst),
        .illegal_instr_in         (illegal_instr),
        .misaligned_instr_in      (misaligned_instr),
        .misaligned_load_in       (misaligned_load),
        .misaligned_store_in      (misaligned_store),
        .opcode_6_to_2_in         (opcode),
        .funct3_in                (funct3),
        .funct7_in                (funct7),
        .rs1_addr_in              (rs1),
        .rs2_addr_in              (rs2),
        .rd_addr_in               (rd),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .pc_src_out               (pc_src),
        .flush_out                (flush),
        .trap_taken_out           (trap_taken),
        .set_epc_out              (set_epc),
        .set_cause_out            (set_cause),
        .cause_out                (cause),
        .i_or_e_out               (i_or_e),
        .mie_clear_out            (mie_clear),
        .mie_set_out              (mie_set),
        .misaligned_exception_out (mis_exc),
        .instret_inc_out          (instret_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        illegal_instr = 0; misaligned_instr = 0; misaligned_load = 0; misaligned_store = 0;
        opcode = 0; funct3 = 0; funct7 = 0; rs1 = 0; rs2 = 0; rd = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    // Drive one trap-causing condition, then check the TRAP_TAKEN cycle and return
    task automatic expect_trap(input string tag, input logic [3:0] c, input logic ie);
        tick();
        chk({tag, "_trap"},   trap_taken, 1);
        chk({tag, "_pcsrc"},  pc_src, 2'b10);
        chk({tag, "_cause"},  cause, c);
        chk({tag, "_ie"},     i_or_e, ie);
        clear_inputs();
        tick();
        chk({tag, "_back"},   pc_src, 2'b11);
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        repeat (3) tick();
        chk("rst_pcsrc", pc_src, 2'b00);
        chk("rst_flush", flush, 1);
        chk("rst_cause", cause, 0);
        chk("rst_strobes", {trap_taken, set_epc, set_cause, mie_clear, mie_set, instret_inc}, 0);
        rst = 1;
        #1;
        chk("rel_pcsrc", pc_src, 2'b00);
        tick();
        chk("op_pcsrc", pc_src, 2'b11);
        chk("op_instret", instret_inc, 1);
        chk("op_flush", flush, 0);

        // ECALL, with the full TRAP_TAKEN strobe set checked once
        opcode = 5'b11100;
        tick();
        chk("ecall_strobes", {flush, trap_taken, set_epc, set_cause, mie_clear, mie_set, instret_inc},
            7'b1111100);
        chk("ecall_cause", cause, 11);
        chk("ecall_ie", i_or_e, 0);
        clear_inputs();
        tick();
        chk("ecall_back", pc_src, 2'b11);
        chk("ecall_hold", cause, 11);

        illegal_instr = 1; misaligned_load = 1;
        #1 chk("mis_exc_op", mis_exc, 1);
        expect_trap("ill_ld", 2, 0);

        misaligned_load = 1;
        tick();
        chk("ld_cause", cause, 4);
        chk("mis_exc_trap", mis_exc, 0);
        chk("ld_again", trap_taken, 1);
        clear_inputs();
        tick();

        misaligned_store = 1;
        expect_trap("st", 6, 0);
        misaligned_instr = 1; illegal_instr = 1;
        expect_trap("mi_ill", 0, 0);
        opcode = 5'b11100; rs2 = 1;
        expect_trap("ebreak", 3, 0);

        // ECALL with rd != 0 is not a SYSTEM trap
        opcode = 5'b11100; rd = 1;
        tick();
        chk("ecall_rd_nt", trap_taken, 0);
        chk("ecall_rd_pc", pc_src, 2'b11);
        clear_inputs();

        mie = 1; mtie = 1; mtip = 1; meie = 1; meip = 1;
        tick();
        chk("irq_ext_cause", cause, 11);
        chk("irq_ext_ie", i_or_e, 1);
        chk("irq_ext_clr", mie_clear, 1);
        clear_inputs();
        tick();

        mie = 1; msie = 1; msip = 1; mtie = 1; mtip = 1;
        expect_trap("irq_sw", 3, 1);
        mie = 1; mtie = 1; mtip = 1;
        expect_trap("irq_tmr", 7, 1);
        mie = 1; mtie = 1; mtip = 1; opcode = 5'b11100; rs2 = 1;
        expect_trap("exc_over_irq", 3, 0);

        mie = 0; mtie = 1; mtip = 1; meie = 1; meip = 1;
        tick();
        chk("irq_off_nt", trap_taken, 0);
        chk("irq_off_inst", instret_inc, 1);
        tick();
        chk("irq_off_nt2", trap_taken, 0);
        clear_inputs();

        opcode = 5'b11100; funct7 = 7'b0011000; rs2 = 5'b00010;
        tick();
        chk("mret_pcsrc", pc_src, 2'b01);
        chk("mret_set", mie_set, 1);
        chk("mret_flush", flush, 1);
        chk("mret_inst", instret_inc, 0);
        chk("mret_nt", trap_taken, 0);
        clear_inputs();
        tick();
        chk("mret_back", pc_src, 2'b11);

        opcode = 5'b11100;
        tick();
        chk("pre_rst_trap", trap_taken, 1);
        clear_inputs();
        rst = 0;
        tick();
        chk("rst_tt_pcsrc", pc_src, 2'b00);
        chk("rst_tt_cause", cause, 0);
        chk("rst_tt_flush", flush, 1);
        rst = 1;
        tick();
        chk("rst_tt_back", pc_src, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
